// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with skid entry, flush-to-bubble and freeze
//
// Purpose: carries a PC plus payload between two CPU pipeline stages using a
// valid/ready handshake. A one-entry skid buffer absorbs a downstream stall so
// in_ready_o depends only on registered state and freeze_i, never on out_ready_i.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   freeze_i              global stall, holds every register
//   flush_i               squash held entries, load bubble into main entry
//   in_valid_i/in_ready_o upstream handshake, pc_i/data_i upstream beat
//   out_valid_o/out_ready_i downstream handshake, pc_o/data_o main entry
//   flush_cnt_o           saturating count of executed flushes

module pipe_stage_reg #(
    parameter int                 PC_W   = 32,
    parameter int                 DATA_W = 32,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
    parameter int                 CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              freeze_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Occupancy is encoded directly by {m_v, s_v}; ST_BAD cannot be reached
    // but is listed so every bit pattern has a name.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BAD   = 2'b01,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    logic              m_v_q,    m_v_d;
    logic [PC_W-1:0]   m_pc_q,   m_pc_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              s_v_q,    s_v_d;
    logic [PC_W-1:0]   s_pc_q,   s_pc_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    state_t state;
    logic   accept;
    logic   drain;

    assign state       = state_t'({m_v_q, s_v_q});
    assign in_ready_o  = ~s_v_q & ~freeze_i;
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = m_v_q & out_ready_i & ~freeze_i;
    assign out_valid_o = m_v_q;
    assign pc_o        = m_pc_q;
    assign data_o      = m_data_q;
    assign flush_cnt_o = flush_cnt_q;

    always_comb begin
        m_v_d       = m_v_q;
        m_pc_d      = m_pc_q;
        m_data_d    = m_data_q;
        s_v_d       = s_v_q;
        s_pc_d      = s_pc_q;
        s_data_d    = s_data_q;
        flush_cnt_d = flush_cnt_q;

        if (freeze_i) begin
            // everything holds; a pending flush waits for freeze to fall
        end else if (flush_i) begin
            // any beat offered this cycle is dropped even though in_ready_o may be 1
            m_v_d    = 1'b0;
            s_v_d    = 1'b0;
            m_pc_d   = pc_i;
            m_data_d = BUBBLE;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_v_d    = 1'b1;
                        m_pc_d   = pc_i;
                        m_data_d = data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        m_pc_d   = pc_i;
                        m_data_d = data_i;
                    end else if (accept) begin
                        s_v_d    = 1'b1;
                        s_pc_d   = pc_i;
                        s_data_d = data_i;
                    end else if (drain) begin
                        // payload fields keep their last values
                        m_v_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        m_pc_d   = s_pc_q;
                        m_data_d = s_data_q;
                        s_v_d    = 1'b0;
                    end
                end
                default: begin
                    // unreachable skid-without-main: discard the orphan skid
                    s_v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_v_q       <= 1'b0;
            m_pc_q      <= '0;
            m_data_q    <= BUBBLE;
            s_v_q       <= 1'b0;
            s_pc_q      <= '0;
            s_data_q    <= BUBBLE;
            flush_cnt_q <= '0;
        end else begin
            m_v_q       <= m_v_d;
            m_pc_q      <= m_pc_d;
            m_data_q    <= m_data_d;
            s_v_q       <= s_v_d;
            s_pc_q      <= s_pc_d;
            s_data_q    <= s_data_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              freeze_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [PC_W-1:0]   pc_i = '0;
    logic [DATA_W-1:0] data_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [PC_W-1:0]   pc_o;
    logic [DATA_W-1:0] data_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    pipe_stage_reg #(
        .PC_W  (PC_W),
        .DATA_W(DATA_W),
        .BUBBLE({DATA_W{1'b0}}),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .freeze_i   (freeze_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .pc_i       (pc_i),
        .data_i     (data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .pc_o       (pc_o),
        .data_o     (data_o),
        .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed vectors: inputs applied for one cycle, expected outputs are the
    // ones visible during that cycle (i.e. the result of all earlier rows).
    typedef struct {
        logic        rst, frz, fl, iv, ordy;
        logic [31:0] pc, data;
        logic        chk;
        logic        ev;
        logic [31:0] epc, edata;
        logic        erdy;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, frz, fl, iv, ordy, input logic [31:0] pc, data,
                       input logic chk, ev, input logic [31:0] epc, edata,
                       input logic erdy, input logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.frz = frz; v.fl = fl; v.iv = iv; v.ordy = ordy;
        v.pc = pc; v.data = data; v.chk = chk; v.ev = ev; v.epc = epc;
        v.edata = edata; v.erdy = erdy; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    // Reference model: an ordered queue of at most two beats plus the last
    // value shown on the outputs when the queue is empty.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] m_hold_pc, m_hold_data;
    int          m_cnt;

    task automatic model_step(input logic rst, frz, fl, iv, ordy, input logic [31:0] pc, data);
        beat_t b;
        bit    dr, ac;
        if (rst) begin
            mq.delete();
            m_hold_pc = 0; m_hold_data = 0; m_cnt = 0;
        end else if (frz) begin
        end else if (fl) begin
            mq.delete();
            m_hold_pc = pc; m_hold_data = 0;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else begin
            dr = (mq.size() > 0) && ordy;
            ac = iv && (mq.size() < 2);
            if (dr) begin
                b = mq.pop_front();
                m_hold_pc = b.pc; m_hold_data = b.data;
            end
            if (ac) begin
                b.pc = pc; b.data = data;
                mq.push_back(b);
            end
        end
    endtask

    initial begin
        logic r, f, fl, iv, od;
        logic [31:0] p, d;

        //   rst frz fl iv ordy pc          data         chk ev epc          edata        rdy cnt
        add(1, 0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   32'h0,  1, 0);
        add(1, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h0,  1, 0);
        add(0, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h0,  1, 0);
        // streaming
        add(0, 0, 0, 1, 1, 32'h100, 32'hA0,   1, 0, 32'h0,   32'h0,  1, 0);
        add(0, 0, 0, 1, 1, 32'h104, 32'hA1,   1, 1, 32'h100, 32'hA0, 1, 0);
        add(0, 0, 0, 1, 1, 32'h108, 32'hA2,   1, 1, 32'h104, 32'hA1, 1, 0);
        add(0, 0, 0, 0, 1, 32'h0,   32'h0,    1, 1, 32'h108, 32'hA2, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h108, 32'hA2, 1, 0);
        // downstream stall into skid
        add(0, 0, 0, 1, 0, 32'h200, 32'hB0,   1, 0, 32'h108, 32'hA2, 1, 0);
        add(0, 0, 0, 1, 0, 32'h204, 32'hB1,   1, 1, 32'h200, 32'hB0, 1, 0);
        add(0, 0, 0, 1, 0, 32'h208, 32'hB2,   1, 1, 32'h200, 32'hB0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,   32'h0,    1, 1, 32'h200, 32'hB0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,   32'h0,    1, 1, 32'h204, 32'hB1, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h204, 32'hB1, 1, 0);
        // flush while FULL with a beat offered
        add(0, 0, 0, 1, 0, 32'h210, 32'hC0,   1, 0, 32'h204, 32'hB1, 1, 0);
        add(0, 0, 0, 1, 0, 32'h214, 32'hC1,   1, 1, 32'h210, 32'hC0, 1, 0);
        add(0, 0, 1, 1, 0, 32'h300, 32'hDD,   1, 1, 32'h210, 32'hC0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0,   32'h0,    1, 0, 32'h300, 32'h0,  1, 1);
        add(0, 0, 0, 0, 1, 32'h0,   32'h0,    1, 0, 32'h300, 32'h0,  1, 1);
        // freeze while ONE with flush, valid and ready all high
        add(0, 0, 0, 1, 0, 32'h400, 32'hE0,   1, 0, 32'h300, 32'h0,  1, 1);
        add(0, 1, 1, 1, 1, 32'h404, 32'hE1,   1, 1, 32'h400, 32'hE0, 0, 1);
        add(0, 1, 1, 1, 1, 32'h404, 32'hE1,   1, 1, 32'h400, 32'hE0, 0, 1);
        add(0, 1, 1, 1, 1, 32'h404, 32'hE1,   1, 1, 32'h400, 32'hE0, 0, 1);
        add(0, 0, 1, 1, 1, 32'h500, 32'hE2,   1, 1, 32'h400, 32'hE0, 1, 1);
        add(0, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h500, 32'h0,  1, 2);
        // counter saturation after a fresh reset
        add(1, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h500, 32'h0,  1, 2);
        add(0, 0, 1, 0, 0, 32'h600, 32'h0,    1, 0, 32'h0,   32'h0,  1, 0);
        add(0, 0, 1, 0, 0, 32'h601, 32'h0,    1, 0, 32'h600, 32'h0,  1, 1);
        add(0, 0, 1, 0, 0, 32'h602, 32'h0,    1, 0, 32'h601, 32'h0,  1, 2);
        add(0, 0, 1, 0, 0, 32'h603, 32'h0,    1, 0, 32'h602, 32'h0,  1, 3);
        add(0, 0, 1, 0, 0, 32'h604, 32'h0,    1, 0, 32'h603, 32'h0,  1, 3);
        add(0, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h604, 32'h0,  1, 3);
        // reset mid-operation wins over freeze and flush
        add(0, 0, 0, 1, 0, 32'h700, 32'hF0,   1, 0, 32'h604, 32'h0,  1, 3);
        add(1, 1, 1, 1, 0, 32'h704, 32'hF1,   1, 1, 32'h700, 32'hF0, 0, 3);
        add(0, 0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h0,  1, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_i = vecs[i].rst; freeze_i = vecs[i].frz; flush_i = vecs[i].fl;
            in_valid_i = vecs[i].iv; out_ready_i = vecs[i].ordy;
            pc_i = vecs[i].pc; data_i = vecs[i].data;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d out_valid", i), {31'b0, out_valid_o}, {31'b0, vecs[i].ev});
                check($sformatf("vec%0d pc_o", i), pc_o, vecs[i].epc);
                check($sformatf("vec%0d data_o", i), data_o, vecs[i].edata);
                check($sformatf("vec%0d in_ready", i), {31'b0, in_ready_o}, {31'b0, vecs[i].erdy});
                check($sformatf("vec%0d flush_cnt", i), {30'b0, flush_cnt_o}, vecs[i].ecnt);
            end
            @(posedge clk);
        end

        // randomized phase against the queue model, starting from reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r  = (c == 0) || ($urandom_range(0, 299) == 0);
            f  = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 15) == 0);
            iv = ($urandom_range(0, 3) != 0);
            od = ($urandom_range(0, 1) != 0);
            p  = $urandom;
            d  = $urandom;
            rst_i = r; freeze_i = f; flush_i = fl; in_valid_i = iv;
            out_ready_i = od; pc_i = p; data_i = d;
            #1;
            if (c > 0) begin
                check("rnd out_valid", {31'b0, out_valid_o}, {31'b0, mq.size() > 0});
                check("rnd pc_o", pc_o, (mq.size() > 0) ? mq[0].pc : m_hold_pc);
                check("rnd data_o", data_o, (mq.size() > 0) ? mq[0].data : m_hold_data);
                check("rnd in_ready", {31'b0, in_ready_o}, {31'b0, (mq.size() < 2) && !f});
                check("rnd flush_cnt", {30'b0, flush_cnt_o}, m_cnt);
            end
            @(posedge clk);
            model_step(r, f, fl, iv, od, p, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, a one-entry skid buffer, flush-to-bubble and a global freeze. It sits between any two CPU pipeline stages (IF/ID, ID/EX, ...) and carries a PC plus a payload word. It replaces per-stage hand-written registers. The skid entry removes the combinational ready path between stages, so a downstream stall never has to propagate upstream in the same cycle.

## Interface
- PC_W, 32, PC field width
- DATA_W, 32, payload width
- BUBBLE, {DATA_W{1'b0}}, payload loaded on flush/reset (NOP encoding)
- CNT_W, 8, flush counter width
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  reset; synchronous, active-high
- freeze_i  in  1  global CPU stall (cache miss); holds every register
- flush_i  in  1  squash all held entries, insert bubble
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  stage can accept a beat
- pc_i  in  PC_W  upstream PC
- data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  main entry valid
- out_ready_i  in  1  downstream accepts main entry
- pc_o  out  PC_W  main entry PC
- data_o  out  DATA_W  main entry payload
- flush_cnt_o  out  CNT_W  saturating count of executed flushes

## Operation
- Storage: main entry {m_v, m_pc, m_data} drives the outputs directly. Skid entry {s_v, s_pc, s_data} is internal.
- accept = in_valid_i & in_ready_o.
- drain = m_v & out_ready_i & ~freeze_i.
- in_ready_o = ~s_v & ~freeze_i. Combinational on freeze_i only; never on out_ready_i.
- out_valid_o = m_v. It stays asserted during freeze, but no transfer occurs while frozen.
- States are derived from {m_v, s_v}: EMPTY (0,0), ONE (1,0), FULL (1,1). The combination (0,1) is illegal and unreachable.
- Priority: rst_i > freeze_i > flush_i > handshake.
- EMPTY
  - accept: main <= input → ONE.
  - otherwise: hold.
- ONE
  - accept & drain: main <= input, stay in ONE.
  - accept & ~drain: skid <= input → FULL.
  - ~accept & drain: m_v <= 0 → EMPTY. m_pc and m_data hold their last values.
  - neither: hold.
- FULL
  - drain: main <= skid, s_v <= 0 → ONE.
  - otherwise: hold. No accept is possible because in_ready_o = 0.
- Flush (flush_i & ~freeze_i)
  - m_v <= 0, s_v <= 0.
  - m_pc <= pc_i, m_data <= BUBBLE.
  - Any beat offered in the same cycle is discarded, even if in_ready_o = 1.
  - State → EMPTY.
  - flush_cnt_o increments by 1, saturating at all-ones.
- Freeze: no register changes, flush_i is ignored, and the counter holds.
- Skid contents are visible only through pc_o/data_o after they move to main, in order. Beats are never reordered or duplicated.

## Timing
- Reset (rst_i high at a posedge) drives:
  - m_v = 0, s_v = 0
  - pc_o = 0, data_o = BUBBLE
  - flush_cnt_o = 0
  - in_ready_o = 1 the following cycle, provided freeze_i = 0.
- Reset asserted mid-operation drops both entries regardless of freeze_i or flush_i.
- Latency: accept at edge N → out_valid_o and data visible after edge N; consumable at edge N+1.
- Throughput is 1 beat/cycle with out_ready_i held high. The skid entry is never used in that case.
- A downstream stall is absorbed by the skid entry. in_ready_o falls one cycle after the stall, driven from the registered s_v.
- Flush and accept in the same cycle: flush wins and the beat is lost.
- Flush while FULL loses both entries.
- Freeze and flush in the same cycle: the flush is ignored. The upstream controller must hold flush_i until freeze_i falls.
- flush_cnt_o at 2^CNT_W−1 stays at that value.

## Test plan
- Reset:
  - Stimulus: rst_i high for 2 cycles, then low.
  - Required: out_valid_o = 0, pc_o = 0, data_o = 0, flush_cnt_o = 0, in_ready_o = 1.
- Streaming:
  - Stimulus: beats pc = 0x100, 0x104, 0x108 with data = 0xA0..0xA2; in_valid_i and out_ready_i held high.
  - Required: each beat appears on the outputs one cycle after its offer; in_ready_o is never 0.
- Downstream stall:
  - Stimulus: out_ready_i = 0 while beats 0x200 and 0x204 are offered.
  - Required: state goes FULL and in_ready_o = 0 on the next cycle.
  - Then, with out_ready_i = 1: 0x200 drains first, then 0x204; no beat is lost or duplicated.
- Flush while FULL:
  - Stimulus: flush_i pulsed for 1 cycle with pc_i = 0x300 and a valid beat offered.
  - Required: out_valid_o = 0, pc_o = 0x300, data_o = BUBBLE, flush_cnt_o +1; the offered beat is never emitted.
- Freeze:
  - Stimulus: freeze_i high for 3 cycles while in ONE, with flush_i, in_valid_i and out_ready_i all high.
  - Required: outputs, counter and state are unchanged; in_ready_o = 0 throughout.
  - After freeze_i falls, the flush executes on the next edge.
- Counter saturation:
  - Stimulus: CNT_W = 2; issue 5 flushes.
  - Required: flush_cnt_o reads 1, 2, 3, 3, 3.
